// File: rtl/seven_seg_pkg.sv
// Seven-segment scan driver shared types and glyph table.
// Provides the active-low hex glyphs, blank code and FSM state type.
package seven_seg_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low {g,f,e,d,c,b,a}, index = hex value.
  localparam logic [6:0] SEG_LUT [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,
    7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03,
    7'h46, 7'h21, 7'h06, 7'h0E
  };

  typedef enum logic {
    ST_BLANK,
    ST_SCAN
  } state_t;

  function automatic logic [6:0] hex_to_seg(
    input logic [3:0] value
  );
    return SEG_LUT[value];
  endfunction

endpackage

// File: rtl/seg_decoder.sv
// Combinational hex nibble to active-low segment pattern.
// Ports: value (4-bit hex in), seg (7-bit {g..a} active-low out).
module seg_decoder
  import seven_seg_pkg::*;
(
  input  logic [3:0] value,
  output logic [6:0] seg
);

  assign seg = hex_to_seg(value);

endmodule

// File: rtl/seven_seg_scan.sv
// Time-multiplexed common-anode display scanner with per-frame snapshot.
// Ports: digits/dp_in/blank_mask/lz_suppress/brightness in; anode/seg/dp/frame_start out.
module seven_seg_scan
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 31250,
  parameter int BRIGHT_W    = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_mask,
  input  logic                    lz_suppress,
  input  logic [BRIGHT_W-1:0]     brightness,
  output logic [NUM_DIGITS-1:0]   anode,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic                    frame_start
);

  localparam int SEL_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(NUM_DIGITS - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

  state_t                  state;
  logic [CNT_W-1:0]        cnt;
  logic [SEL_W-1:0]        sel;
  logic [SEL_W-1:0]        sel_nxt;
  logic [BRIGHT_W-1:0]     pwm_cnt;
  logic [4*NUM_DIGITS-1:0] snap_digits;
  logic [NUM_DIGITS-1:0]   snap_dp;
  logic [NUM_DIGITS-1:0]   snap_blank;
  logic [NUM_DIGITS-1:0]   lz_dark;
  logic                    zero_run;
  logic                    tick;
  logic                    lit;
  logic [3:0]              nibble;
  logic [6:0]              glyph;

  assign tick = (cnt == CNT_LAST);

  // Leaving BLANK always starts at digit 0.
  always_comb begin
    sel_nxt = '0;
    if (state == ST_SCAN && sel != SEL_LAST) begin
      sel_nxt = sel + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_BLANK;
      cnt         <= '0;
      sel         <= '0;
      pwm_cnt     <= '0;
      snap_digits <= '0;
      snap_dp     <= '0;
      snap_blank  <= '0;
    end else begin
      if (tick) begin
        cnt     <= '0;
        pwm_cnt <= '0;
        state   <= ST_SCAN;
        sel     <= sel_nxt;
        if (sel_nxt == '0) begin
          snap_digits <= digits;
          snap_dp     <= dp_in;
          snap_blank  <= blank_mask;
        end
      end else begin
        cnt     <= cnt + 1'b1;
        pwm_cnt <= pwm_cnt + 1'b1;
      end
    end
  end

  // A digit is suppressed while every more significant
  // snapshot digit, and itself, is zero.
  always_comb begin
    lz_dark  = '0;
    zero_run = lz_suppress;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      zero_run   = zero_run && (snap_digits[4*i +: 4] == 4'h0);
      lz_dark[i] = zero_run;
    end
  end

  assign nibble = snap_digits[4*sel +: 4];

  seg_decoder u_dec (
    .value (nibble),
    .seg   (glyph)
  );

  assign lit = (state == ST_SCAN)
            && !snap_blank[sel]
            && !lz_dark[sel]
            && (pwm_cnt <= brightness);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      anode       <= '1;
      seg         <= SEG_BLANK;
      dp          <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      anode       <= lit ? ~(NUM_DIGITS'(1) << sel) : '1;
      seg         <= lit ? glyph : SEG_BLANK;
      dp          <= lit ? ~snap_dp[sel] : 1'b1;
      // cnt==0 with sel==0 in SCAN only right after a frame-wrapping tick.
      frame_start <= (state == ST_SCAN) && (cnt == '0) && (sel == '0);
    end
  end

endmodule

// File: tb/tb_seven_seg_scan.sv
// Testbench for seven_seg_scan: cycle-count model plus directed literal checks.
// Drives inputs on negedge, compares outputs on negedge.
module tb_seven_seg_scan;

  localparam int N  = 4;
  localparam int R  = 8;
  localparam int BW = 3;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [4*N-1:0]  digits = '0;
  logic [N-1:0]    dp_in = '0;
  logic [N-1:0]    blank_mask = '0;
  logic            lz_suppress = 1'b0;
  logic [BW-1:0]   brightness = '1;
  logic [N-1:0]    anode;
  logic [6:0]      seg;
  logic            dp;
  logic            frame_start;

  int checks = 0;
  int fails  = 0;
  bit run    = 0;

  always #5 clk = ~clk;

  seven_seg_scan #(
    .NUM_DIGITS (N),
    .REFRESH_DIV(R),
    .BRIGHT_W   (BW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .digits     (digits),
    .dp_in      (dp_in),
    .blank_mask (blank_mask),
    .lz_suppress(lz_suppress),
    .brightness (brightness),
    .anode      (anode),
    .seg        (seg),
    .dp         (dp),
    .frame_start(frame_start)
  );

  logic [6:0] gly [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  // Model: e = number of clock edges since reset release.
  int             n;
  logic [4*N-1:0] m_dig;
  logic [N-1:0]   m_dp;
  logic [N-1:0]   m_blk;
  logic [12:0]    e_out;

  function automatic logic [12:0] model_out(input int e);
    int q, p, d;
    logic lzd, lit;
    logic [3:0] an;
    logic [6:0] sg;
    logic dpo, fs;
    if (e <= R) return {1'b0, 1'b1, 7'h7F, 4'hF};
    q   = e - R - 1;
    p   = q % R;
    d   = (q / R) % N;
    fs  = (q % (N * R)) == 0;
    lzd = 1'b0;
    if (lz_suppress && d >= 1) begin
      lzd = 1'b1;
      for (int j = d; j < N; j++)
        if (m_dig[j*4 +: 4] != 4'h0) lzd = 1'b0;
    end
    lit = !m_blk[d] && !lzd && ((p % (1 << BW)) <= int'(brightness));
    an  = 4'hF;
    sg  = 7'h7F;
    dpo = 1'b1;
    if (lit) begin
      an     = 4'hF;
      an[d]  = 1'b0;
      sg     = gly[m_dig[d*4 +: 4]];
      dpo    = ~m_dp[d];
    end
    return {fs, dpo, sg, an};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n     <= 0;
      m_dig <= '0;
      m_dp  <= '0;
      m_blk <= '0;
      e_out <= {1'b0, 1'b1, 7'h7F, 4'hF};
    end else begin
      e_out <= model_out(n + 1);
      n     <= n + 1;
      if (n + 1 >= R && ((n + 1 - R) % (N * R)) == 0) begin
        m_dig <= digits;
        m_dp  <= dp_in;
        m_blk <= blank_mask;
      end
    end
  end

  always @(negedge clk) begin
    if (run) begin
      checks++;
      if ({frame_start, dp, seg, anode} !== e_out) begin
        fails++;
        $display("FAIL model t=%0t got fs=%b dp=%b seg=%b an=%b exp fs=%b dp=%b seg=%b an=%b",
                 $time, frame_start, dp, seg, anode,
                 e_out[12], e_out[11], e_out[10:4], e_out[3:0]);
      end
    end
  end

  task automatic chk(input string nm, input logic [3:0] ea,
                     input logic [6:0] es);
    checks++;
    if (anode !== ea || seg !== es) begin
      fails++;
      $display("FAIL %s got an=%b seg=%b exp an=%b seg=%b",
               nm, anode, seg, ea, es);
    end
  endtask

  task automatic chk_dp(input string nm, input logic ed);
    checks++;
    if (dp !== ed) begin
      fails++;
      $display("FAIL %s got dp=%b exp dp=%b", nm, dp, ed);
    end
  endtask

  task automatic wait_fs(input string nm);
    bit seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (frame_start === 1'b1) seen = 1;
    end
    checks++;
    if (!seen) begin
      fails++;
      $display("FAIL %s got no frame_start exp pulse within 200 cycles", nm);
    end
  endtask

  task automatic step(input int k);
    repeat (k) @(negedge clk);
  endtask

  logic [3:0] scan_an [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
  logic [6:0] scan_sg [4] = '{7'b0011001, 7'b0110000,
                              7'b0100100, 7'b1111001};

  initial begin
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2 run = 1;
    chk("reset", 4'hF, 7'h7F);
    chk_dp("reset_dp", 1'b1);
    checks++;
    if (frame_start !== 1'b0) begin
      fails++;
      $display("FAIL reset_fs got %b exp 0", frame_start);
    end

    // Basic scan
    digits = 16'h1234;
    step(2);
    rst_n = 1'b1;
    wait_fs("fs_first");
    for (int i = 0; i < 4; i++) begin
      if (i > 0) step(R);
      chk($sformatf("scan%0d", i), scan_an[i], scan_sg[i]);
    end

    // Snapshot: change during digit 1 slot
    wait_fs("fs_snap");
    step(R);
    digits = 16'hABCD;
    step(R);
    chk("snap_d2_old", 4'b1011, 7'b0100100);
    step(R);
    chk("snap_d3_old", 4'b0111, 7'b1111001);
    wait_fs("fs_snap_new");
    chk("snap_d0_new", 4'b1110, 7'b0100001);

    // Leading-zero suppression
    lz_suppress = 1'b1;
    digits = 16'h0040;
    wait_fs("fs_lz");
    chk("lz_d0", 4'b1110, 7'b1000000);
    step(R);
    chk("lz_d1", 4'b1101, 7'b0011001);
    step(R);
    chk("lz_d2", 4'hF, 7'h7F);
    step(R);
    chk("lz_d3", 4'hF, 7'h7F);
    digits = 16'h0000;
    wait_fs("fs_lz0");
    chk("lz0_d0", 4'b1110, 7'b1000000);
    step(R);
    chk("lz0_d1", 4'hF, 7'h7F);

    // Brightness, mask, decimal point
    lz_suppress = 1'b0;
    digits = 16'h1234;
    brightness = 3'd2;
    blank_mask = 4'b0100;
    dp_in = 4'b0001;
    wait_fs("fs_br");
    chk("br_p0", 4'b1110, 7'b0011001);
    chk_dp("dp_d0", 1'b0);
    step(1);
    chk("br_p1", 4'b1110, 7'b0011001);
    step(1);
    chk("br_p2", 4'b1110, 7'b0011001);
    step(1);
    chk("br_p3", 4'hF, 7'h7F);
    step(5);
    chk("br_d1", 4'b1101, 7'b0110000);
    chk_dp("dp_d1", 1'b1);
    step(R);
    chk("mask_d2", 4'hF, 7'h7F);

    // Asynchronous reset while digit 3 is lit
    brightness = 3'd7;
    blank_mask = 4'b0000;
    step(R);
    chk("pre_rst_d3", 4'b0111, 7'b1111001);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk("async_rst", 4'hF, 7'h7F);
    chk_dp("async_rst_dp", 1'b1);
    step(3);
    rst_n = 1'b1;
    for (int i = 0; i < R; i++) begin
      step(1);
      chk($sformatf("post_rst_dark%0d", i), 4'hF, 7'h7F);
    end
    step(1);
    chk("post_rst_d0", 4'b1110, 7'b0011001);
    step(2 * N * R);

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
